// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 default timing constants and shared output types for vga_sync_gen
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int COORD_W   = 10;
    localparam int MAX_TOTAL = 1024;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               video_on;
        logic [COORD_W-1:0] px;
        logic [COORD_W-1:0] py;
        logic               line_start;
        logic               frame_start;
    } vga_out_t;

    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    // Idle raster: syncs deasserted, blanked, no strobes.
    function automatic vga_out_t vga_out_rst(input logic sync_pol);
        vga_out_t r;
        r             = '0;
        r.hsync       = ~sync_pol;
        r.vsync       = ~sync_pol;
        return r;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// rtl/vga_axis_cnt.sv - wrap counter 0..TOTAL-1 advancing on i_inc, o_wrap flags the last count
module vga_axis_cnt #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    logic [W-1:0] r_cnt;

    assign o_wrap = (r_cnt == W'(TOTAL - 1));
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_wrap ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator; VGA_FRAME_CNT_EN adds a 16-bit frame counter output
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] px,
    output logic [COORD_W-1:0] py,
    output logic               line_start,
    output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = cnt_width(H_TOTAL);
    localparam int VW       = cnt_width(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
            $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
        end
    endgenerate

    logic [HW-1:0] w_hc;
    logic [VW-1:0] w_vc;
    logic          w_h_wrap;
    logic          w_v_wrap_unused;
    logic          w_hc_zero;
    logic          w_vc_zero;
    vga_out_t      w_dec;
    vga_out_t      r_out;

    vga_axis_cnt #(.TOTAL(H_TOTAL), .W(HW)) u_h_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_inc  (en),
        .o_cnt  (w_hc),
        .o_wrap (w_h_wrap)
    );

    // Vertical advances only on the last pixel of each line.
    vga_axis_cnt #(.TOTAL(V_TOTAL), .W(VW)) u_v_cnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_inc  (en & w_h_wrap),
        .o_cnt  (w_vc),
        .o_wrap (w_v_wrap_unused)
    );

    assign w_hc_zero = (w_hc == '0);
    assign w_vc_zero = (w_vc == '0);

    always_comb begin
        w_dec             = '0;
        w_dec.hsync       = (int'(w_hc) >= HS_START && int'(w_hc) <= HS_END) ? SYNC_POL : ~SYNC_POL;
        w_dec.vsync       = (int'(w_vc) >= VS_START && int'(w_vc) <= VS_END) ? SYNC_POL : ~SYNC_POL;
        w_dec.video_on    = (int'(w_hc) < H_ACTIVE) && (int'(w_vc) < V_ACTIVE);
        w_dec.px          = w_dec.video_on ? COORD_W'(w_hc) : '0;
        w_dec.py          = w_dec.video_on ? COORD_W'(w_vc) : '0;
        w_dec.line_start  = w_hc_zero;
        w_dec.frame_start = w_hc_zero & w_vc_zero;
    end

    // Levels freeze while en is low so syncs never glitch; strobes drop to 0.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_out <= vga_out_rst(SYNC_POL);
        end else if (en) begin
            r_out <= w_dec;
        end else begin
            r_out.line_start  <= 1'b0;
            r_out.frame_start <= 1'b0;
        end
    end

    assign hsync       = r_out.hsync;
    assign vsync       = r_out.vsync;
    assign video_on    = r_out.video_on;
    assign px          = r_out.px;
    assign py          = r_out.py;
    assign line_start  = r_out.line_start;
    assign frame_start = r_out.frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_frame_cnt <= '0;
        end else if (en && w_hc_zero && w_vc_zero) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen (default 640x480 instance plus a reduced-raster instance)
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic [9:0] px;
        logic [9:0] py;
        logic       line_start;
        logic       frame_start;
    } exp_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       clr_n_a, en_a, clr_n_b, en_b;
    logic       a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_px, a_py;
    logic       b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0] b_px, b_py;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] a_fcnt, b_fcnt;
`endif

    vga_sync_gen u_dut_a (
        .clk         (clk),
        .clr_n       (clr_n_a),
        .en          (en_a),
        .hsync       (a_hs),
        .vsync       (a_vs),
        .video_on    (a_von),
        .px          (a_px),
        .py          (a_py),
        .line_start  (a_ls),
        .frame_start (a_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (a_fcnt)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1)
    ) u_dut_b (
        .clk         (clk),
        .clr_n       (clr_n_b),
        .en          (en_b),
        .hsync       (b_hs),
        .vsync       (b_vs),
        .video_on    (b_von),
        .px          (b_px),
        .py          (b_py),
        .line_start  (b_ls),
        .frame_start (b_fs)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (b_fcnt)
`endif
    );

    int   p_ha[2]  = '{640, 8};
    int   p_hfp[2] = '{16, 2};
    int   p_hs[2]  = '{96, 3};
    int   p_hbp[2] = '{48, 2};
    int   p_va[2]  = '{480, 6};
    int   p_vfp[2] = '{10, 1};
    int   p_vs[2]  = '{2, 2};
    int   p_vbp[2] = '{33, 1};
    logic p_pol[2] = '{1'b0, 1'b1};

    int          m_hc[2];
    int          m_vc[2];
    exp_t        m_last[2];
    logic [15:0] m_fcnt[2];
    exp_t        sb_a[$];
    exp_t        sb_b[$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t rst_val(input int w);
        exp_t r;
        r       = '0;
        r.hsync = ~p_pol[w];
        r.vsync = ~p_pol[w];
        return r;
    endfunction

    function automatic exp_t decode(input int w, input int hc, input int vc);
        exp_t r;
        int   hs0;
        int   vs0;
        hs0           = p_ha[w] + p_hfp[w];
        vs0           = p_va[w] + p_vfp[w];
        r.hsync       = (hc >= hs0 && hc < hs0 + p_hs[w]) ? p_pol[w] : ~p_pol[w];
        r.vsync       = (vc >= vs0 && vc < vs0 + p_vs[w]) ? p_pol[w] : ~p_pol[w];
        r.video_on    = (hc < p_ha[w]) && (vc < p_va[w]);
        r.px          = r.video_on ? 10'(hc) : 10'd0;
        r.py          = r.video_on ? 10'(vc) : 10'd0;
        r.line_start  = (hc == 0);
        r.frame_start = (hc == 0) && (vc == 0);
        return r;
    endfunction

    task automatic model_reset(input int w);
        m_hc[w]   = 0;
        m_vc[w]   = 0;
        m_last[w] = rst_val(w);
        m_fcnt[w] = 16'd0;
    endtask

    task automatic model_step(input int w, input logic e, output exp_t r);
        int htot;
        int vtot;
        htot = p_ha[w] + p_hfp[w] + p_hs[w] + p_hbp[w];
        vtot = p_va[w] + p_vfp[w] + p_vs[w] + p_vbp[w];
        if (e) begin
            m_last[w] = decode(w, m_hc[w], m_vc[w]);
            if (m_last[w].frame_start) m_fcnt[w] = m_fcnt[w] + 16'd1;
            if (m_hc[w] == htot - 1) begin
                m_hc[w] = 0;
                m_vc[w] = (m_vc[w] == vtot - 1) ? 0 : m_vc[w] + 1;
            end else begin
                m_hc[w] = m_hc[w] + 1;
            end
        end else begin
            m_last[w].line_start  = 1'b0;
            m_last[w].frame_start = 1'b0;
        end
        r = m_last[w];
    endtask

    function automatic exp_t obs_a();
        return {a_hs, a_vs, a_von, a_px, a_py, a_ls, a_fs};
    endfunction

    function automatic exp_t obs_b();
        return {b_hs, b_vs, b_von, b_px, b_py, b_ls, b_fs};
    endfunction

    task automatic tick(input logic ea, input logic eb);
        exp_t e;
        en_a = ea;
        en_b = eb;
        model_step(0, ea, e);
        sb_a.push_back(e);
        model_step(1, eb, e);
        sb_b.push_back(e);
        @(posedge clk);
        #1;
        chk("scoreboard_a", 32'(obs_a()), 32'(sb_a.pop_front()));
        chk("scoreboard_b", 32'(obs_b()), 32'(sb_b.pop_front()));
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt_a", 32'(a_fcnt), 32'(m_fcnt[0]));
        chk("frame_cnt_b", 32'(b_fcnt), 32'(m_fcnt[1]));
`endif
    endtask

    initial begin
        int ls_cnt, fs_cnt, von_cnt, vs_cnt;
        int hs_cnt, hs_first, hs_last, ls_first, hs_hi;

        clr_n_a = 1'b0;
        clr_n_b = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b0;
        model_reset(0);
        model_reset(1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("reset_a", 32'(obs_a()), 32'(rst_val(0)));
        chk("reset_b", 32'(obs_b()), 32'(rst_val(1)));
        chk("reset_a_hsync_high", 32'(a_hs), 32'd1);
        #3;
        clr_n_a = 1'b1;
        clr_n_b = 1'b1;

        // One full default line.
        ls_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 1; i <= 800; i++) begin
            tick(1'b1, 1'b0);
            if (i == 1) begin
                chk("first_edge_frame_start", 32'(a_fs), 32'd1);
                chk("first_edge_video_on", 32'(a_von), 32'd1);
            end
            if (a_ls) ls_cnt++;
            if (a_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
                hs_last = i;
            end
        end
        chk("line_start_per_line", ls_cnt, 1);
        chk("hsync_first_low_edge", hs_first, 657);
        chk("hsync_low_cycles", hs_cnt, 96);
        chk("hsync_last_low_edge", hs_last, 752);

        // Pause at hc=700 inside the hsync pulse.
        for (int i = 0; i < 700; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            chk("pause_hsync", 32'(a_hs), 32'd0);
            chk("pause_video_on", 32'(a_von), 32'd0);
            chk("pause_px", 32'(a_px), 32'd0);
            chk("pause_line_start", 32'(a_ls), 32'd0);
        end
        ls_first = -1; hs_hi = -1;
        for (int i = 1; i <= 200; i++) begin
            tick(1'b1, 1'b0);
            if (a_ls && ls_first < 0) ls_first = i;
            if (a_hs && hs_hi < 0) hs_hi = i;
        end
        chk("resume_line_start_edge", ls_first, 101);
        chk("resume_hsync_release_edge", hs_hi, 53);

        // Reduced raster (15x10), one full frame.
        ls_cnt = 0; fs_cnt = 0; von_cnt = 0; vs_cnt = 0;
        for (int i = 1; i <= 150; i++) begin
            tick(1'b0, 1'b1);
            if (b_ls) ls_cnt++;
            if (b_fs) fs_cnt++;
            if (b_von) von_cnt++;
            if (b_vs) vs_cnt++;
            if (i == 83) begin
                chk("corner_px", 32'(b_px), 32'd7);
                chk("corner_py", 32'(b_py), 32'd5);
                chk("corner_video_on", 32'(b_von), 32'd1);
            end
            if (i == 84) begin
                chk("after_corner_video_on", 32'(b_von), 32'd0);
                chk("after_corner_px", 32'(b_px), 32'd0);
                chk("after_corner_py", 32'(b_py), 32'd0);
            end
        end
        chk("frame_start_count", fs_cnt, 1);
        chk("line_start_count", ls_cnt, 10);
        chk("video_on_cycles", von_cnt, 48);
        chk("vsync_cycles", vs_cnt, 30);

        // Mid-frame asynchronous clear at hc=5, vc=3.
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b1);
        chk("pre_clear_video_on", 32'(b_von), 32'd1);
        chk("pre_clear_px", 32'(b_px), 32'd4);
        #5;
        clr_n_b = 1'b0;
        #1;
        chk("async_clear_b", 32'(obs_b()), 32'(rst_val(1)));
        model_reset(1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #3;
        clr_n_b = 1'b1;
        tick(1'b0, 1'b1);
        chk("post_clear_frame_start", 32'(b_fs), 32'd1);
        chk("post_clear_line_start", 32'(b_ls), 32'd1);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
